mc_ctrlunit: RTL

Multi-cycle control unit for the next-generation CPU datapath. It decodes a parametrised-width opcode and sequences FETCH/DECODE/EXEC/MEM/WB through a state machine. Memory accesses use a ready handshake with an optional timeout, and the unit halts on the HALT opcode, on an illegal opcode, or on a bus timeout. It sits between the instruction register and the shared datapath (ALU, register file, PC, memory port), replacing the single-cycle decoder.

---
 rtl/cpu_pkg.sv | 102 ++++++++++
 rtl/mc_waitcnt.sv | 34 +++
 rtl/mc_ctrlunit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, control-unit states, ALU operation codes,
// program-counter source selects and the opcode classification helper.
package cpu_pkg;

  // Low 4 bits of the opcode carry the operation; wider opcodes must keep
  // their upper bits at zero.
  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_ADDC = 4'd4,
    OP_SUBC = 4'd5,
    OP_SLT  = 4'd6,
    OP_ADDI = 4'd7,
    OP_ANDI = 4'd8,
    OP_ORI  = 4'd9,
    OP_LW   = 4'd10,
    OP_SW   = 4'd11,
    OP_BEQ  = 4'd12,
    OP_BNE  = 4'd13,
    OP_JMP  = 4'd14,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  // Shared ALU interface operation codes.
  localparam logic [2:0] AC_AN  = 3'd0;  // and
  localparam logic [2:0] AC_OR  = 3'd1;  // or
  localparam logic [2:0] AC_ADX = 3'd2;  // add, no carry in
  localparam logic [2:0] AC_SBX = 3'd3;  // subtract, no borrow in
  localparam logic [2:0] AC_AD  = 3'd4;  // add with carry
  localparam logic [2:0] AC_SB  = 3'd5;  // subtract with borrow
  localparam logic [2:0] AC_LS  = 3'd6;  // set on less-than

  // PC source selects.
  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef struct packed {
    logic       is_rtype;
    logic       is_imm;
    logic       wrflag;
    logic [2:0] aluc;
  } op_class_t;

  // Datapath control word driven by the sequencer.
  typedef struct packed {
    logic       memreq;
    logic       memwe;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
    logic       alusrcb;
    logic       aluoutwe;
    logic       writereg;
    logic       memtoreg;
    logic       regdes;
    logic       wrflag;
    logic       retire;
  } ctrl_t;

  // Opcode classes, unchanged from the single-cycle decoder.
  function automatic op_class_t op_class(input logic [OPC_W-1:0] op);
    op_class_t c;
    c = '0;
    c.is_rtype = (op <= OP_SLT);
    unique case (opcode_e'(op))
      OP_AND:  begin c.aluc = AC_AN;                                end
      OP_OR:   begin c.aluc = AC_OR;                                end
      OP_ADD:  begin c.aluc = AC_ADX; c.wrflag = 1'b1;              end
      OP_SUB:  begin c.aluc = AC_SBX; c.wrflag = 1'b1;              end
      OP_ADDC: begin c.aluc = AC_AD;  c.wrflag = 1'b1;              end
      OP_SUBC: begin c.aluc = AC_SB;  c.wrflag = 1'b1;              end
      OP_SLT:  begin c.aluc = AC_LS;                                end
      OP_ADDI: begin c.aluc = AC_ADX; c.wrflag = 1'b1; c.is_imm = 1'b1; end
      OP_ANDI: begin c.aluc = AC_AN;  c.is_imm = 1'b1;              end
      OP_ORI:  begin c.aluc = AC_OR;  c.is_imm = 1'b1;              end
      OP_LW:   begin c.aluc = AC_ADX; c.is_imm = 1'b1;              end
      OP_SW:   begin c.aluc = AC_ADX; c.is_imm = 1'b1;              end
      OP_BEQ:  begin c.aluc = AC_SBX;                               end
      OP_BNE:  begin c.aluc = AC_SBX;                               end
      default: begin c.aluc = AC_AN;                                end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_waitcnt.sv
// Memory wait counter: counts stalled request cycles and flags a timeout when
// the stall reaches MEMWAIT_MAX cycles with the ready still low.
import cpu_pkg::*;

module mc_waitcnt #(
  parameter int MEMWAIT_MAX = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic memrdy,
  output logic timeout
);

  localparam int CW = $clog2(MEMWAIT_MAX + 1);

  logic [CW-1:0] count;

  // A ready on the limit cycle wins over the timeout.
  assign timeout = active && !memrdy && (count == CW'(MEMWAIT_MAX));

  // Count stalled cycles; any completion, timeout or leaving the access state clears.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count <= '0;
    end else if (active && !memrdy && !timeout) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/mc_ctrlunit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB for the shared
// datapath, handshakes memory accesses and halts on HALT, illegal opcodes or
// bus timeouts.
import cpu_pkg::*;

module mc_ctrlunit #(
  parameter int OPW         = 4,
  parameter int MEMWAIT_MAX = 0
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] OP,
  input  logic           ZERO,
  input  logic           MEMRDY,
  output logic           MEMREQ,
  output logic           MEMWE,
  output logic           IORD,
  output logic           IRWRITE,
  output logic           PCWRITE,
  output logic [1:0]     PCSRC,
  output logic [2:0]     ALUC,
  output logic           ALUSRCB,
  output logic           ALUOUTWE,
  output logic           WRITEREG,
  output logic           MEMTOREG,
  output logic           REGDES,
  output logic           WRFLAG,
  output logic           RETIRE,
  output logic           HALTED,
  output logic           ILLEGAL,
  output logic           BUSERR
);

  state_e           state;
  state_e           state_next;
  ctrl_t            ctrl;
  op_class_t        cls;
  logic [OPC_W-1:0] opc;
  logic             upper_bad;
  logic             timeout;
  logic             set_illegal;
  logic             set_buserr;
  logic             illegal_q;
  logic             buserr_q;

  assign opc = OP[OPC_W-1:0];
  assign cls = op_class(opc);

  // Any set bit above the 4-bit operation field makes the opcode illegal.
  generate
    if (OPW > OPC_W) begin : g_upper
      assign upper_bad = |OP[OPW-1:OPC_W];
    end else begin : g_no_upper
      assign upper_bad = 1'b0;
    end
  endgenerate

  // The wait counter exists only when a timeout limit is configured.
  generate
    if (MEMWAIT_MAX > 0) begin : g_waitcnt
      logic mem_active;
      assign mem_active = (state == S_FETCH) || (state == S_MEM);
      mc_waitcnt #(
        .MEMWAIT_MAX (MEMWAIT_MAX)
      ) u_waitcnt (
        .clk     (CLK),
        .rst     (RST),
        .active  (mem_active),
        .memrdy  (MEMRDY),
        .timeout (timeout)
      );
    end else begin : g_no_waitcnt
      assign timeout = 1'b0;
    end
  endgenerate

  // State register and sticky halt-cause bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
      buserr_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_buserr)  buserr_q  <= 1'b1;
    end
  end

  // Next-state and control decode from state, opcode and memory ready.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_next  = state;
    ctrl        = '0;
    set_illegal = 1'b0;
    set_buserr  = 1'b0;

    unique case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end

      S_FETCH: begin
        ctrl.memreq = 1'b1;
        if (MEMRDY) begin
          ctrl.irwrite = 1'b1;
          ctrl.pcwrite = 1'b1;
          ctrl.pcsrc   = PC_INC;
          state_next   = S_DECODE;
        end else if (timeout) begin
          set_buserr = 1'b1;
          state_next = S_HALT;
        end
      end

      S_DECODE: begin
        if (upper_bad) begin
          set_illegal = 1'b1;
          state_next  = S_HALT;
        end else if (opc == OP_JMP) begin
          ctrl.pcwrite = 1'b1;
          ctrl.pcsrc   = PC_JUMP;
          ctrl.retire  = 1'b1;
          state_next   = S_FETCH;
        end else if (opc == OP_HALT) begin
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        ctrl.aluc     = cls.aluc;
        ctrl.alusrcb  = cls.is_imm;
        ctrl.aluoutwe = 1'b1;
        if (opc == OP_BEQ || opc == OP_BNE) begin
          ctrl.pcwrite = (opc == OP_BEQ) ? ZERO : !ZERO;
          ctrl.pcsrc   = PC_BRANCH;
          ctrl.retire  = 1'b1;
          state_next   = S_FETCH;
        end else if (opc == OP_LW || opc == OP_SW) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end

      S_MEM: begin
        ctrl.memreq = 1'b1;
        ctrl.iord   = 1'b1;
        ctrl.memwe  = (opc == OP_SW);
        if (MEMRDY) begin
          if (opc == OP_SW) begin
            ctrl.retire = 1'b1;
            state_next  = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (timeout) begin
          set_buserr = 1'b1;
          state_next = S_HALT;
        end
      end

      S_WB: begin
        ctrl.writereg = 1'b1;
        ctrl.memtoreg = (opc == OP_LW);
        ctrl.regdes   = cls.is_rtype;
        ctrl.wrflag   = cls.wrflag;
        ctrl.retire   = 1'b1;
        state_next    = S_FETCH;
      end

      S_HALT: begin
        state_next = S_HALT;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign MEMREQ   = ctrl.memreq;
  assign MEMWE    = ctrl.memwe;
  assign IORD     = ctrl.iord;
  assign IRWRITE  = ctrl.irwrite;
  assign PCWRITE  = ctrl.pcwrite;
  assign PCSRC    = ctrl.pcsrc;
  assign ALUC     = ctrl.aluc;
  assign ALUSRCB  = ctrl.alusrcb;
  assign ALUOUTWE = ctrl.aluoutwe;
  assign WRITEREG = ctrl.writereg;
  assign MEMTOREG = ctrl.memtoreg;
  assign REGDES   = ctrl.regdes;
  assign WRFLAG   = ctrl.wrflag;
  assign RETIRE   = ctrl.retire;
  assign HALTED   = (state == S_HALT);
  assign ILLEGAL  = illegal_q;
  assign BUSERR   = buserr_q;

endmodule
